// File: rtl/calc_data_stack_pkg.sv
// Shared widths and error-cause encodings for the calculator operand stack.
package calc_data_stack_pkg;

  localparam int CD_N     = 16;  // number register width
  localparam int CDS_CNT_N = 5;  // stack depth counter width

  typedef enum logic [1:0] {
    CDS_ERR_NONE = 2'd0,
    CDS_ERR_OVF  = 2'd1,
    CDS_ERR_UNF  = 2'd2
  } cds_err_cause_e;

endpackage

// File: rtl/calc_data_stack.sv
// Operand LIFO for the calculator controller: registered top-of-stack, depth
// counter, sticky overflow/underflow flag.
module calc_data_stack
  import calc_data_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = CD_N,
  parameter int CNT_N = CDS_CNT_N
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     dt_data,
  output logic             dt_empty,
  output logic             dt_full,
  output logic [CNT_N-1:0] dt_count,
  output logic             dt_err,
  output cds_err_cause_e   dt_err_cause
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

  logic [W-1:0]     r_top_q;
  logic [W-1:0]     r_mem [DEPTH-1];
  logic [CNT_N-1:0] r_count;
  logic             r_err;
  cds_err_cause_e   r_err_cause;

  logic             w_empty;
  logic             w_full;
  logic             w_one;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_spill;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_N'(DEPTH));
  assign w_one    = (r_count == CNT_N'(1));
  assign w_wr_idx = AW'(r_count - CNT_N'(1));
  assign w_rd_idx = AW'(r_count - CNT_N'(2));

  // Old top moves into the array only on a plain push onto a non-empty, non-full stack.
  assign w_spill  = Reset && !clear && push && !pop && !w_full && !w_empty;

  always_ff @(posedge Clock) begin
    if (!Reset || clear) begin
      r_count     <= '0;
      r_top_q     <= '0;
      r_err       <= 1'b0;
      r_err_cause <= CDS_ERR_NONE;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (w_full) begin
            r_err       <= 1'b1;
            r_err_cause <= CDS_ERR_OVF;
          end else begin
            r_top_q <= push_data;
            r_count <= r_count + CNT_N'(1);
          end
        end
        2'b01: begin
          if (w_empty) begin
            r_err       <= 1'b1;
            r_err_cause <= CDS_ERR_UNF;
          end else if (w_one) begin
            r_top_q <= '0;
            r_count <= '0;
          end else begin
            r_top_q <= r_mem[w_rd_idx];
            r_count <= r_count - CNT_N'(1);
          end
        end
        2'b11: begin
          if (w_empty) begin
            r_err       <= 1'b1;
            r_err_cause <= CDS_ERR_UNF;
          end else begin
            r_top_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; entries are only read below a valid count,
  // so a reset would cost a mux per bit for nothing.
  always_ff @(posedge Clock) begin
    if (w_spill) r_mem[w_wr_idx] <= r_top_q;
  end

  assign dt_data      = r_top_q;
  assign dt_empty     = w_empty;
  assign dt_full      = w_full;
  assign dt_count     = r_count;
  assign dt_err       = r_err;
  assign dt_err_cause = r_err_cause;

endmodule

// File: tb/tb_calc_data_stack.sv
// Directed self-checking bench for calc_data_stack.
module tb_calc_data_stack;
  import calc_data_stack_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = CD_N;
  localparam int CNT_N = CDS_CNT_N;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             clear;
  logic             push;
  logic             pop;
  logic [W-1:0]     push_data;
  logic [W-1:0]     dt_data;
  logic             dt_empty;
  logic             dt_full;
  logic [CNT_N-1:0] dt_count;
  logic             dt_err;
  cds_err_cause_e   dt_err_cause;

  int n_cmp = 0;
  int n_bad = 0;

  calc_data_stack #(.DEPTH(DEPTH), .W(W), .CNT_N(CNT_N)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .push_data    (push_data),
    .dt_data      (dt_data),
    .dt_empty     (dt_empty),
    .dt_full      (dt_full),
    .dt_count     (dt_count),
    .dt_err       (dt_err),
    .dt_err_cause (dt_err_cause)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs across one rising edge, then settle past it.
  task automatic step();
    @(posedge Clock);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    Reset = 1'b1;
  endtask

  task automatic do_push(input logic [W-1:0] d);
    push = 1'b1; push_data = d; step();
  endtask

  task automatic do_pop();
    pop = 1'b1; step();
  endtask

  task automatic do_swap(input logic [W-1:0] d);
    push = 1'b1; pop = 1'b1; push_data = d; step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step();
  endtask

  initial begin
    Reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
    #2;
    Reset = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;

    check("rst_data",  dt_data,  0);
    check("rst_empty", dt_empty, 1);
    check("rst_full",  dt_full,  0);
    check("rst_count", dt_count, 0);
    check("rst_err",   dt_err,   0);

    // LIFO order
    do_push(16'd5);
    check("push1_data", dt_data, 5);
    do_push(16'd7);
    do_push(16'd9);
    check("push3_data",  dt_data,  9);
    check("push3_count", dt_count, 3);
    check("push3_empty", dt_empty, 0);
    do_pop();
    check("pop1_data", dt_data, 7);
    do_pop();
    check("pop2_data", dt_data, 5);
    do_pop();
    check("pop3_data",  dt_data,  0);
    check("pop3_empty", dt_empty, 1);
    check("pop3_count", dt_count, 0);
    check("lifo_err",   dt_err,   0);

    // Fill, then replace the top while full
    for (int i = 1; i <= DEPTH; i++) do_push(W'(i));
    check("fill_full",  dt_full,  1);
    check("fill_count", dt_count, 16);
    check("fill_data",  dt_data,  16);
    do_swap(16'h2A);
    check("swapfull_count", dt_count, 16);
    check("swapfull_data",  dt_data,  16'h2A);
    check("swapfull_err",   dt_err,   0);

    // Drain: every array entry comes back in reverse order
    for (int i = DEPTH - 1; i >= 1; i--) begin
      do_pop();
      check($sformatf("drain_%0d", i), dt_data, i);
    end
    check("drain_count", dt_count, 1);
    do_pop();
    check("drain_empty", dt_empty, 1);
    check("drain_data",  dt_data,  0);

    // Overflow
    for (int i = 1; i <= DEPTH; i++) do_push(W'(i));
    do_push(16'd99);
    check("ovf_full",  dt_full,  1);
    check("ovf_data",  dt_data,  16);
    check("ovf_count", dt_count, 16);
    check("ovf_err",   dt_err,   1);
    check("ovf_cause", dt_err_cause, CDS_ERR_OVF);
    do_pop();
    check("ovf_pop_data", dt_data, 15);
    check("ovf_sticky",   dt_err,  1);

    do_clear();
    check("clr_count", dt_count, 0);
    check("clr_data",  dt_data,  0);
    check("clr_err",   dt_err,   0);

    // Underflow on an empty stack
    do_pop();
    check("unf_err",   dt_err,   1);
    check("unf_count", dt_count, 0);
    check("unf_cause", dt_err_cause, CDS_ERR_UNF);
    do_clear();
    check("unf_clr_err", dt_err, 0);

    do_swap(16'h55);
    check("swap_empty_err",   dt_err,   1);
    check("swap_empty_count", dt_count, 0);
    check("swap_empty_data",  dt_data,  0);
    do_clear();

    // Clear wins over a simultaneous push
    do_push(16'd1);
    clear = 1'b1; push = 1'b1; push_data = 16'd2; step();
    check("clr_prio_count", dt_count, 0);
    check("clr_prio_data",  dt_data,  0);

    // Replace top
    do_push(16'd3);
    do_push(16'd4);
    do_swap(16'd8);
    check("swap_count", dt_count, 2);
    check("swap_data",  dt_data,  8);
    do_pop();
    check("swap_pop_data", dt_data, 3);
    check("swap_err",      dt_err,  0);
    do_pop();

    // Reset in the same cycle as a push
    do_push(16'd1);
    do_push(16'd2);
    do_push(16'd3);
    Reset = 1'b0; push = 1'b1; push_data = 16'd4; step();
    check("midrst_count", dt_count, 0);
    check("midrst_data",  dt_data,  0);
    check("midrst_empty", dt_empty, 1);
    check("midrst_err",   dt_err,   0);

    do_push(16'hBEEF);
    check("post_rst_data",  dt_data,  16'hBEEF);
    check("post_rst_count", dt_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_data_stack.md
# calc_data_stack

Operand (data) stack of the calculator controller. It holds pending number operands while operators wait on precedence, and it is the responder on the `dt_*` memory port. The controller pushes the current number register value into it and reads/pops `dt_data` back into the number register during evaluation. It is a LIFO with a registered top-of-stack, a depth counter and a sticky error flag for overflow and underflow.

## Interface
Parameters:
- `DEPTH`, 16: number of entries, at least 2.
- `W`, `` `CD_N ``: entry width, equal to the number register width.
- `CNT_N`, 5: counter width, must hold the value `DEPTH`.

Ports:
- `Clock`  in  1: rising-edge clock.
- `Reset`  in  1: synchronous, active-low.
- `clear`  in  1: empties the stack and clears `dt_err`.
- `push`  in  1: push `push_data`.
- `pop`  in  1: discard top-of-stack.
- `push_data`  in  W: value to push, normally the number register output.
- `dt_data`  out  W: current top-of-stack.
- `dt_empty`  out  1: count is 0.
- `dt_full`  out  1: count equals `DEPTH`.
- `dt_count`  out  CNT_N: current number of entries.
- `dt_err`  out  1: sticky flag for overflow or underflow.

## Operation
- Storage:
  - Top entry is held in register `top_q`.
  - The remaining DEPTH-1 entries are held in array `mem`, indexed by `count-2` for the entry just below top.
- `dt_data` is driven directly from `top_q`. There is no read latency.
- `dt_data` is 0 when the stack is empty. `top_q` is cleared whenever count reaches 0.
- Priority, evaluated each cycle: `~Reset` > `clear` > command.
- Commands:
  - **Idle** (`push`=0, `pop`=0): no change.
  - **Push**, not full:
    - `mem[count-1] <= top_q` if count>0.
    - `top_q <= push_data`.
    - count+1.
  - **Push** when full: no state change; `dt_err <= 1`.
  - **Pop**, count>1:
    - `top_q <= mem[count-2]`.
    - count-1.
  - **Pop**, count==1: `top_q <= 0`; count becomes 0.
  - **Pop** when empty: no state change; `dt_err <= 1`.
  - **Push and pop together**, count>0: replace the top. `top_q <= push_data`, count unchanged, never an error, even when full.
  - **Push and pop together**, count==0: treated as an underflow. `dt_err <= 1`, no state change.
- `dt_err` clears only on `clear` or reset.
- Array contents are never reset. Only `count`, `top_q` and `dt_err` are initialized.
- Control state is `count`; the derived conditions are EMPTY (0), PARTIAL, and FULL (`DEPTH`). Transitions happen only through the rules above, and `count` never goes outside 0..DEPTH.

## Timing
- All updates occur on the rising edge of `Clock`.
- Reset values: `dt_data`=0, `dt_empty`=1, `dt_full`=0, `dt_count`=0, `dt_err`=0.
- Reset is synchronous. It takes effect at the first edge with `Reset`=0 and overrides any push/pop in that same cycle.
- Asserting reset in the middle of a sequence leaves the stack empty on the following cycle.
- Latency:
  - After a push at edge N, `dt_data` shows the pushed value immediately after edge N.
  - After a pop at edge N, `dt_data` shows the next entry immediately after edge N.
  - The controller may therefore pop in one cycle and read the new top in the next state.
- Status outputs are combinational from registered `count`, so they are glitch-free relative to `Clock`.
- There is no handshake. The controller must not issue push when `dt_full` is set or pop when `dt_empty` is set; violations are flagged, not stalled.

## Structure
- `CNT_N` and the error-cause encodings belong in CONT_INTERNAL.v as `` `CDS_* `` defines, next to the existing controller state defines.
- An optional debug output `dt_err_cause` (overflow vs underflow) uses those defines.
- No sub-module. The block is a single always block for sequential state plus continuous assigns for status.
- The controller instantiates the block and drives `push`, `pop` and `clear` from its state decode.

## Test plan
- **Reset and push/pop order:** Reset low for 1 cycle, then push 5, 7, 9.
  - After the pushes: `dt_data`=9, count=3.
  - Then pop ×3: `dt_data` becomes 7, then 5, then 0, with `dt_empty`=1 at the end.
  - `dt_err` stays 0 throughout.
- **Overflow:** fill to `DEPTH` (16) with values 1..16, then push 99.
  - Required: `dt_full`=1, `dt_data`=16, count=16, `dt_err`=1.
- **Underflow, then clear:** on an empty stack, pop.
  - Required: `dt_err`=1, count=0.
  - Then assert `clear`: `dt_err`=0.
- **Replace top:** push 3, push 4, then push=pop=1 with data 8.
  - Required: count=2, `dt_data`=8.
  - Then pop: `dt_data`=3.
- **Replace top when full:** at count=16, push=pop=1 with data 0x2A.
  - Required: count=16, `dt_data`=0x2A, `dt_err`=0.
- **Reset mid-sequence:** push 1, 2, 3, then Reset=0 in the same cycle as push 4.
  - Required next cycle: count=0, `dt_data`=0, `dt_empty`=1, `dt_err`=0.
